// File: rtl/hex_mem_pkg.sv
// hex_mem_pkg
//   Shared definitions for the 16-bit data/frame memory subsystem.
//   - own_e  : read-return owner encoding (which requester gets mem_rdata
//              in the cycle after a grant)
//   - HEX_ADDR_W / HEX_DATA_W : default memory word-address / data widths
package hex_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VGA  = 2'd1,
      OWN_CPU  = 2'd2
   } own_e;

   localparam int HEX_ADDR_W = 16;
   localparam int HEX_DATA_W = 16;

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares the single-port frame/data RAM between the VGA pixel fetcher and
//   the CPU load/store port. At most one grant per cycle, zero-latency when
//   unblocked; read data returns one cycle after the grant to whoever owned
//   that access. VGA has priority, but after VGA_BURST_MAX consecutive VGA
//   grants against a waiting CPU, the CPU takes the next slot.
//
//   Ports
//     clk, rst          clock, asynchronous active-low reset
//     vga_req/addr      VGA read request (held until vga_gnt)
//     vga_gnt           VGA access accepted this cycle
//     vga_rvalid/rdata  VGA read return, one cycle after vga_gnt
//     cpu_req/we/addr/wdata  CPU access request (held until cpu_gnt)
//     cpu_gnt           CPU access accepted (write completion for writes)
//     cpu_rvalid/rdata  CPU read return, one cycle after a read grant
//     mem_en/we/addr/wdata   RAM command, driven in the grant cycle
//     mem_rdata         RAM read data, valid the cycle after a read
module vram_arbiter
   import hex_mem_pkg::*;
#(
   parameter int ADDR_W        = HEX_ADDR_W,
   parameter int DATA_W        = HEX_DATA_W,
   parameter int VGA_BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [3:0] BURST_MAX = 4'(VGA_BURST_MAX);

   logic [3:0] burst_cnt, burst_nxt;
   own_e       rd_owner, owner_nxt;
   logic       cpu_turn, vga_win, cpu_win;

   // Grant decision. Grants are masked by rst so nothing leaks onto the RAM
   // bus while reset is held, even though this path is purely combinational.
   always_comb begin
      cpu_turn = cpu_req && (burst_cnt == BURST_MAX);
      vga_win  = rst && vga_req && !cpu_turn;
      cpu_win  = rst && cpu_req && !vga_win;
   end

   // Burst counter only counts VGA grants that a waiting CPU had to watch;
   // any cycle without a CPU request wipes the history.
   always_comb begin
      burst_nxt = burst_cnt;
      if (!cpu_req || cpu_win)
         burst_nxt = '0;
      else if (vga_win && burst_cnt != BURST_MAX)
         burst_nxt = burst_cnt + 4'd1;
   end

   // Owner of the data coming back from the RAM next cycle. Writes and
   // idle cycles produce no return.
   always_comb begin
      owner_nxt = OWN_NONE;
      if (vga_win)
         owner_nxt = OWN_VGA;
      else if (cpu_win && !cpu_we)
         owner_nxt = OWN_CPU;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_cnt <= '0;
         rd_owner  <= OWN_NONE;
      end else begin
         burst_cnt <= burst_nxt;
         rd_owner  <= owner_nxt;
      end
   end

   always_comb begin
      vga_gnt    = vga_win;
      cpu_gnt    = cpu_win;
      mem_en     = vga_win || cpu_win;
      mem_we     = cpu_win && cpu_we;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (vga_win)
         mem_addr = vga_addr;
      else if (cpu_win) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
      vga_rvalid = (rd_owner == OWN_VGA);
      cpu_rvalid = (rd_owner == OWN_CPU);
      // RAM output is not reset, so the pass-through is masked during reset.
      vga_rdata  = rst ? mem_rdata : '0;
      cpu_rdata  = rst ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Directed bench for vram_arbiter. A small synchronous RAM model serves the
//   DUT; a behavioural model (shadow memory, starvation count, pending-return
//   record) is checked against every output on every falling edge, and the
//   directed sequence adds hand-computed literal checks.
module tb_vram_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int BMAX = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vga_req = 1'b0;
   logic [AW-1:0] vga_addr = '0;
   logic          vga_gnt, vga_rvalid;
   logic [DW-1:0] vga_rdata;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_gnt, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   int n_cmp = 0;
   int n_bad = 0;

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VGA_BURST_MAX(BMAX)) dut (
      .clk(clk), .rst(rst),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
      .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_word(int a);
      logic [7:0] b;
      b = 8'(a);
      return {b, b} ^ 16'hA5A5;
   endfunction

   // RAM attached to the arbiter
   logic [15:0] ram [256];
   initial for (int i = 0; i < 256; i++) ram[i] = init_word(i);
   always @(posedge clk)
      if (mem_en) begin
         if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[7:0]];
      end

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] shadow [256];
   int          m_wait;      // VGA wins seen by a currently waiting CPU
   int          m_ret;       // 0 none, 1 VGA, 2 CPU return due this cycle
   logic [15:0] m_data;
   initial for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
   initial begin m_wait = 0; m_ret = 0; m_data = '0; end

   always @(negedge clk) begin
      bit ev, ec;
      logic [15:0] ea;
      if (!rst) begin
         m_wait = 0; m_ret = 0;
         check("rst_vga_gnt", vga_gnt, 0);   check("rst_cpu_gnt", cpu_gnt, 0);
         check("rst_mem_en", mem_en, 0);     check("rst_mem_we", mem_we, 0);
         check("rst_mem_addr", mem_addr, 0); check("rst_mem_wdata", mem_wdata, 0);
         check("rst_vga_rvalid", vga_rvalid, 0); check("rst_cpu_rvalid", cpu_rvalid, 0);
         check("rst_vga_rdata", vga_rdata, 0);   check("rst_cpu_rdata", cpu_rdata, 0);
      end else begin
         ev = vga_req && !(cpu_req && m_wait >= BMAX);
         ec = cpu_req && !ev;
         ea = ev ? vga_addr : (ec ? cpu_addr : 16'h0);
         check("m_vga_gnt", vga_gnt, ev);
         check("m_cpu_gnt", cpu_gnt, ec);
         check("m_mem_en", mem_en, ev | ec);
         check("m_mem_we", mem_we, ec & cpu_we);
         check("m_mem_addr", mem_addr, ea);
         if (ec && cpu_we) check("m_mem_wdata", mem_wdata, cpu_wdata);
         if (!ev && !ec)   check("m_idle_wdata", mem_wdata, 0);
         check("m_vga_rvalid", vga_rvalid, m_ret == 1);
         check("m_cpu_rvalid", cpu_rvalid, m_ret == 2);
         if (m_ret == 1) check("m_vga_rdata", vga_rdata, m_data);
         if (m_ret == 2) check("m_cpu_rdata", cpu_rdata, m_data);
         check("m_burst_cnt", dut.burst_cnt, m_wait);
         // advance model to the next cycle
         m_data = shadow[ea[7:0]];
         if (ec && cpu_we) shadow[ea[7:0]] = cpu_wdata;
         m_ret = ev ? 1 : ((ec && !cpu_we) ? 2 : 0);
         if (!cpu_req || ec) m_wait = 0;
         else if (ev && m_wait < BMAX) m_wait = m_wait + 1;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic samp();
      @(negedge clk); #1;
   endtask

   initial begin
      logic [9:0] pat;
      // reset with both requesting
      vga_req = 1; vga_addr = 16'd3; cpu_req = 1; cpu_addr = 16'd9;
      repeat (3) tick();
      samp();
      check("lit_rst_vga_gnt", vga_gnt, 0);
      check("lit_rst_mem_en", mem_en, 0);
      tick(); rst = 1;
      samp();
      check("lit_first_vga_gnt", vga_gnt, 1);
      check("lit_first_cpu_gnt", cpu_gnt, 0);
      check("lit_first_addr", mem_addr, 3);
      tick(); vga_req = 0; cpu_req = 0;

      // CPU write then read
      tick(); cpu_req = 1; cpu_we = 1; cpu_addr = 16'd4; cpu_wdata = 16'h1234;
      samp(); check("lit_cpu_wr_gnt", cpu_gnt, 1); check("lit_cpu_wr_we", mem_we, 1);
      tick(); cpu_we = 0;
      samp(); check("lit_cpu_rd_gnt", cpu_gnt, 1);
      tick(); cpu_req = 0;
      samp(); check("lit_cpu_rvalid", cpu_rvalid, 1);
      check("lit_cpu_rdata", cpu_rdata, 16'h1234);

      // VGA streaming reads 0..7
      for (int i = 0; i < 8; i++) begin
         tick(); vga_req = 1; vga_addr = 16'(i);
         samp(); check("lit_vga_gnt", vga_gnt, 1);
         check("lit_vga_rvalid", vga_rvalid, i > 0);
         check("lit_vga_cpu_rvalid", cpu_rvalid, 0);
         if (i == 1) check("lit_vga_rdata0", vga_rdata, 16'hA5A5);
      end
      tick(); vga_req = 0;
      samp(); check("lit_vga_last_rvalid", vga_rvalid, 1);
      check("lit_vga_rdata7", vga_rdata, 16'hA2A2);

      // contention: both held for 10 cycles
      tick(); vga_req = 1; vga_addr = 16'd10; cpu_req = 1; cpu_we = 0; cpu_addr = 16'd4;
      pat = '0;
      for (int c = 0; c < 10; c++) begin
         samp(); pat[c] = cpu_gnt;
         if (c > 0 && pat[c-1]) check("lit_burst_clr", dut.burst_cnt, 0);
         if (c < 9) tick();
      end
      check("lit_contention_pattern", pat, 10'b10000_10000);
      tick(); vga_req = 0; cpu_req = 0;

      // interleave: CPU read in N, VGA in N+1
      tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'd4;
      samp(); check("lit_il_cpu_gnt", cpu_gnt, 1);
      tick(); cpu_req = 0; vga_req = 1; vga_addr = 16'd2;
      samp(); check("lit_il_vga_gnt", vga_gnt, 1);
      check("lit_il_cpu_rvalid", cpu_rvalid, 1); check("lit_il_vga_rvalid0", vga_rvalid, 0);
      check("lit_il_cpu_rdata", cpu_rdata, 16'h1234);
      tick(); vga_req = 0;
      samp(); check("lit_il_vga_rvalid", vga_rvalid, 1); check("lit_il_cpu_rvalid0", cpu_rvalid, 0);
      check("lit_il_vga_rdata", vga_rdata, 16'hA7A7);

      // reset pulse between a read grant and its return
      tick(); cpu_req = 1; cpu_addr = 16'd4; vga_req = 1; vga_addr = 16'd1;
      samp(); check("lit_rp_vga_gnt", vga_gnt, 1);
      rst = 0; cpu_req = 0; vga_req = 0;
      tick();
      samp(); check("lit_rp_vga_rvalid_rst", vga_rvalid, 0);
      tick(); rst = 1;
      samp(); check("lit_rp_vga_rvalid", vga_rvalid, 0);
      check("lit_rp_cpu_rvalid", cpu_rvalid, 0);
      check("lit_rp_burst", dut.burst_cnt, 0);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
